router_input_buffer: RTL and testbench



---
 rtl/router_pkg.sv | 20 ++
 rtl/router_fifo.sv | 64 ++++++
 rtl/router_input_buffer.sv | 130 +++++++++++++
 tb/tb_router_input_buffer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and framing constants for the router input-port logic.
package router_pkg;

    localparam int FLIT_WIDTH_DEF = 16;

    typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SEND
    } buf_state_t;

    // Position of the flit being forwarded within its packet
    typedef logic [1:0] flit_idx_t;
    localparam flit_idx_t HEADER_IDX  = 2'd0;
    localparam flit_idx_t SIZE_IDX    = 2'd1;
    localparam flit_idx_t PAYLOAD_IDX = 2'd2;

endpackage

// File: rtl/router_fifo.sv
// Circular flit buffer: write-then-read, no bypass, head always visible on rdata.
module router_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             empty_next
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign empty_next = (count_d == '0);
    assign rdata      = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/router_input_buffer.sv
// Router input port: buffers link flits and forwards whole packets to the switch
// via header-request / data-valid handshakes, tracking framing to find packet ends.
//
// state  | meaning
// S_IDLE | no packet in flight; waits for a flit at the FIFO head
// S_REQ  | header at head, h asserted until the switch control acks
// S_SEND | packet being forwarded; data_av whenever the FIFO holds a flit
module router_input_buffer
    import router_pkg::*;
#(
    parameter int FLIT_WIDTH   = 16,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [FLIT_WIDTH-1:0] data_i,
    output logic                  credit_o,
    output logic                  h,
    input  logic                  ack_h,
    output logic                  data_av,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  data_ack,
    output logic                  sender,
    output logic                  overflow_o
);

    buf_state_t            state_q, state_d;
    flit_idx_t             flit_idx_q, flit_idx_d;
    logic [FLIT_WIDTH-1:0] remaining_q, remaining_d;
    logic                  h_q, h_d;
    logic                  data_av_q, data_av_d;
    logic                  sender_q, sender_d;
    logic                  overflow_q, overflow_d;

    logic push, pop;
    logic fifo_full, fifo_empty, fifo_empty_next;

    assign credit_o = !reset && !fifo_full;
    assign push     = rx && credit_o;
    assign pop      = data_av_q && data_ack;

    router_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .wdata      (data_i),
        .rdata      (data_o),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .empty_next (fifo_empty_next)
    );

    always_comb begin
        state_d     = state_q;
        flit_idx_d  = flit_idx_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q || (rx && !credit_o);

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                flit_idx_d = HEADER_IDX;
                if (ack_h) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (pop) begin
                    case (flit_idx_q)
                        HEADER_IDX: flit_idx_d = SIZE_IDX;
                        SIZE_IDX: begin
                            remaining_d = data_o;
                            flit_idx_d  = PAYLOAD_IDX;
                            if (data_o == '0) begin
                                state_d = S_IDLE;
                            end
                        end
                        default: begin
                            remaining_d = remaining_q - FLIT_WIDTH'(1);
                            if (remaining_q == FLIT_WIDTH'(1)) begin
                                state_d = S_IDLE;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from next state so they line up with state_q
        h_d       = (state_d == S_REQ);
        sender_d  = (state_d == S_SEND);
        data_av_d = sender_d && !fifo_empty_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            flit_idx_q  <= HEADER_IDX;
            remaining_q <= '0;
            h_q         <= 1'b0;
            data_av_q   <= 1'b0;
            sender_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flit_idx_q  <= flit_idx_d;
            remaining_q <= remaining_d;
            h_q         <= h_d;
            data_av_q   <= data_av_d;
            sender_q    <= sender_d;
            overflow_q  <= overflow_d;
        end
    end

    assign h          = h_q;
    assign data_av    = data_av_q;
    assign sender     = sender_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_router_input_buffer.sv
// Randomized bench for router_input_buffer with a packet-level scoreboard.
module tb_router_input_buffer;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        rx;
    logic [15:0] data_i;
    logic        credit_o;
    logic        h;
    logic        ack_h;
    logic        data_av;
    logic [15:0] data_o;
    logic        data_ack;
    logic        sender;
    logic        overflow_o;

    router_input_buffer #(
        .FLIT_WIDTH   (16),
        .BUFFER_DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .h          (h),
        .ack_h      (ack_h),
        .data_av    (data_av),
        .data_o     (data_o),
        .data_ack   (data_ack),
        .sender     (sender),
        .overflow_o (overflow_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    task automatic chkw(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %04h expected %04h at %0t", nm, act, exp, $time);
    endtask

    // Reference model state (updated by the monitor)
    logic [15:0] sb[$];
    bit          in_pkt  = 0;
    bit          exp_h   = 0;
    bit          exp_ovf = 0;
    bit          rst_prev = 0;
    int          pos = 0;
    int          left = 0;
    int          h_rises = 0;

    int   ack_mode = 0;
    int   dack_mode = 1;
    logic dack_manual = 1'b0;

    // Responder: switch control and crossbar side
    initial begin : responder
        int hc;
        hc = 0;
        ack_h = 1'b0;
        data_ack = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            hc = h ? hc + 1 : 0;
            ack_h = (ack_mode == 0) ? (hc >= 2) : ($urandom_range(0, 2) == 0);
            case (dack_mode)
                0: data_ack = 1'b0;
                1: data_ack = 1'b1;
                2: data_ack = ~data_ack;
                3: data_ack = ($urandom_range(0, 1) == 1);
                default: data_ack = dack_manual;
            endcase
        end
    end

    // Monitor: compares DUT outputs with the packet-level model each cycle
    initial begin : monitor
        int          sz;
        bit          exp_credit, exp_dav, h_prev;
        logic [15:0] v;
        h_prev = 0;
        forever begin
            @(negedge clock);
            if (h && !h_prev) h_rises++;
            h_prev = h;
            if (reset) begin
                chkb("rst_credit", credit_o, 1'b0);
                if (rst_prev) begin
                    chkb("rst_h", h, 1'b0);
                    chkb("rst_data_av", data_av, 1'b0);
                    chkb("rst_sender", sender, 1'b0);
                    chkb("rst_overflow", overflow_o, 1'b0);
                end
                sb.delete();
                in_pkt = 0; exp_h = 0; exp_ovf = 0; pos = 0; left = 0;
            end else begin
                sz = sb.size();
                exp_credit = (sz != DEPTH);
                exp_dav = in_pkt && (sz != 0);
                chkb("credit_o", credit_o, exp_credit);
                chkb("overflow_o", overflow_o, exp_ovf);
                chkb("sender", sender, in_pkt);
                chkb("h", h, exp_h);
                chkb("data_av", data_av, exp_dav);
                if (in_pkt) begin
                    if (exp_dav && data_ack) begin
                        v = sb.pop_front();
                        chkw("data_o", data_o, v);
                        if (pos == 0) begin
                            pos = 1;
                        end else if (pos == 1) begin
                            left = int'(v);
                            pos = 2;
                            if (left == 0) in_pkt = 0;
                        end else begin
                            left--;
                            if (left == 0) in_pkt = 0;
                        end
                    end
                end else if (exp_h) begin
                    if (ack_h) begin
                        in_pkt = 1; exp_h = 0; pos = 0;
                    end
                end else begin
                    exp_h = (sz != 0);
                end
                if (rx) begin
                    if (exp_credit) sb.push_back(data_i);
                    else exp_ovf = 1;
                end
            end
            rst_prev = reset;
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1; rx = 1'b1; data_i = 16'($urandom);
        @(posedge clock); #1;
        data_i = 16'($urandom);
        @(posedge clock); #1;
        reset = 1'b0; rx = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            rx = 1'b0;
        end
    endtask

    // Offer one flit, only when the port grants credit; gap_pct inserts random bubbles
    task automatic send(input logic [15:0] v, input int gap_pct);
        bit sent;
        sent = 0;
        for (int t = 0; t < 1000 && !sent; t++) begin
            @(posedge clock); #1;
            if (credit_o && ($urandom_range(0, 99) >= gap_pct)) begin
                rx = 1'b1; data_i = v; sent = 1;
            end else begin
                rx = 1'b0;
            end
        end
        chkb("send_credit_wait", sent, 1'b1);
    endtask

    task automatic drain();
        bit busy;
        @(posedge clock); #1;
        rx = 1'b0;
        busy = 1;
        for (int t = 0; t < 1000 && busy; t++) begin
            @(negedge clock); #1;
            busy = (sb.size() != 0) || in_pkt;
        end
        chkb("drain_done_busy", busy, 1'b0);
    endtask

    task automatic send_packet(input int size, input int gap_pct);
        send(16'($urandom), gap_pct);
        send(16'(size), gap_pct);
        for (int i = 0; i < size; i++) send(16'($urandom), gap_pct);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int hs;
        reset = 1'b1; rx = 1'b0; data_i = '0;

        // Reset with rx held high, then quiet cycles
        do_reset();
        idle(4);

        // Single packet, ack one cycle after h, data_ack held high
        ack_mode = 0; dack_mode = 1;
        send(16'h0102, 0);
        send(16'h0003, 0);
        @(negedge clock);
        chkb("t2_h_not_yet", h, 1'b0);
        send(16'h00A1, 0);
        @(negedge clock);
        chkb("t2_h_rise", h, 1'b1);
        send(16'h00A2, 0);
        send(16'h00A3, 0);
        drain();

        // Fill to full with no consumption, 9th flit dropped
        do_reset();
        dack_mode = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock); #1;
            rx = 1'b1;
            data_i = (i == 1) ? 16'd6 : 16'($urandom);
            if (i == 8) begin
                @(negedge clock);
                chkb("t3_full_credit", credit_o, 1'b0);
            end
        end
        @(posedge clock); #1;
        rx = 1'b0;
        @(negedge clock);
        chkb("t3_overflow_set", overflow_o, 1'b1);

        // Full with simultaneous offer and consume
        @(posedge clock); #1;
        rx = 1'b1; data_i = 16'($urandom);
        dack_mode = 4; dack_manual = 1'b1;
        @(posedge clock); #1;
        rx = 1'b0; dack_manual = 1'b0;
        @(negedge clock);
        chkb("t4_credit_back", credit_o, 1'b1);
        dack_mode = 1;
        drain();

        // Zero-size packet followed by a one-payload packet
        do_reset();
        ack_mode = 0; dack_mode = 1;
        hs = h_rises;
        send(16'($urandom), 0);
        send(16'h0000, 0);
        send(16'($urandom), 0);
        send(16'h0001, 0);
        send(16'h00BB, 0);
        drain();
        chkw("t5_h_requests", 16'(h_rises - hs), 16'd2);

        // Long packet across pointer wrap, toggling consume, mid-packet starvation
        dack_mode = 2;
        send(16'($urandom), 0);
        send(16'd18, 0);
        for (int i = 0; i < 18; i++) begin
            send(16'($urandom), 0);
            if (i == 8) idle(8);
        end
        drain();

        // Randomized packets and handshakes
        ack_mode = 1; dack_mode = 3;
        for (int p = 0; p < 10; p++) send_packet($urandom_range(0, 5), 30);
        drain();

        // Reset in the middle of a packet, then a clean packet
        send_packet(6, 0);
        do_reset();
        ack_mode = 0; dack_mode = 1;
        send_packet(2, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
